// File: rtl/rename_register_file.sv
// Architectural register file with per-register ROB rename tags, two zero-latency dependency queries.
// Optional same-cycle commit forwarding into the query ports: define REGFILE_COMMIT_BYPASS_EN.
module rename_register_file #(
    parameter int XLEN     = 32,
    parameter int REG_NUM  = 32,
    parameter int ROB_ID_W = 5,
    localparam int RID_W   = $clog2(REG_NUM)
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    input  logic                _clear,
    input  logic                _rf_launch_ready,
    input  logic [ROB_ID_W-1:0] _rf_launch_rob_id,
    input  logic [RID_W-1:0]    _rf_launch_register_id,
    input  logic                _rf_commit_ready,
    input  logic [ROB_ID_W-1:0] _rf_commit_rob_id,
    input  logic [RID_W-1:0]    _rf_commit_register_id,
    input  logic [XLEN-1:0]     _rf_commit_value,
    input  logic [RID_W-1:0]    _ask_rd_1,
    input  logic [RID_W-1:0]    _ask_rd_2,
    output logic [ROB_ID_W-1:0] _dep_rd_1,
    output logic [XLEN-1:0]     _dep_value_1,
    output logic [ROB_ID_W-1:0] _dep_rd_2,
    output logic [XLEN-1:0]     _dep_value_2
);

    logic [XLEN-1:0]     value_q [REG_NUM];
    logic [XLEN-1:0]     value_d [REG_NUM];
    logic [ROB_ID_W-1:0] tag_q   [REG_NUM];
    logic [ROB_ID_W-1:0] tag_d   [REG_NUM];

    // Entry 0 is never written here, so x0 stays at its reset value of 0/0.
    always_comb begin
        value_d = value_q;
        tag_d   = tag_q;
        if (rdy_in) begin
            for (int r = 1; r < REG_NUM; r++) begin
                if (_rf_commit_ready && _rf_commit_register_id == RID_W'(r))
                    value_d[r] = _rf_commit_value;
                // A mid-flight launch owns the register ahead of any commit clear.
                if (_clear)
                    tag_d[r] = '0;
                else if (_rf_launch_ready && _rf_launch_register_id == RID_W'(r))
                    tag_d[r] = _rf_launch_rob_id;
                else if (_rf_commit_ready && _rf_commit_register_id == RID_W'(r)
                         && tag_q[r] == _rf_commit_rob_id)
                    tag_d[r] = '0;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int r = 0; r < REG_NUM; r++) begin
                value_q[r] <= '0;
                tag_q[r]   <= '0;
            end
        end else begin
            value_q <= value_d;
            tag_q   <= tag_d;
        end
    end

`ifdef REGFILE_COMMIT_BYPASS_EN
    function automatic logic bypass_hit(input logic [RID_W-1:0] ask);
        return _rf_commit_ready && _rf_commit_register_id == ask && ask != '0
               && tag_q[ask] == _rf_commit_rob_id;
    endfunction
`endif

    always_comb begin
        _dep_rd_1    = tag_q[_ask_rd_1];
        _dep_value_1 = value_q[_ask_rd_1];
        _dep_rd_2    = tag_q[_ask_rd_2];
        _dep_value_2 = value_q[_ask_rd_2];
`ifdef REGFILE_COMMIT_BYPASS_EN
        if (bypass_hit(_ask_rd_1)) begin
            _dep_rd_1    = '0;
            _dep_value_1 = _rf_commit_value;
        end
        if (bypass_hit(_ask_rd_2)) begin
            _dep_rd_2    = '0;
            _dep_value_2 = _rf_commit_value;
        end
`endif
    end

endmodule

// File: tb/tb_rename_register_file.sv
// Directed + randomized bench for rename_register_file against an array-based reference model.
// Follows REGFILE_COMMIT_BYPASS_EN when defined for the build.
module tb_rename_register_file;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        clr;
    logic        l_rdy;
    logic [4:0]  l_rob;
    logic [4:0]  l_reg;
    logic        c_rdy;
    logic [4:0]  c_rob;
    logic [4:0]  c_reg;
    logic [31:0] c_val;
    logic [4:0]  ask1, ask2;
    logic [4:0]  dep1, dep2;
    logic [31:0] val1, val2;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] m_val [32];
    logic [4:0]  m_tag [32];

    always #5 clk = ~clk;

    rename_register_file dut (
        .clk_in                 (clk),
        .rst_in                 (rst),
        .rdy_in                 (rdy),
        ._clear                 (clr),
        ._rf_launch_ready       (l_rdy),
        ._rf_launch_rob_id      (l_rob),
        ._rf_launch_register_id (l_reg),
        ._rf_commit_ready       (c_rdy),
        ._rf_commit_rob_id      (c_rob),
        ._rf_commit_register_id (c_reg),
        ._rf_commit_value       (c_val),
        ._ask_rd_1              (ask1),
        ._dep_rd_1              (dep1),
        ._dep_value_1           (val1),
        ._ask_rd_2              (ask2),
        ._dep_rd_2              (dep2),
        ._dep_value_2           (val2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic bypass(input logic [4:0] a);
`ifdef REGFILE_COMMIT_BYPASS_EN
        return c_rdy && c_reg == a && a != 0 && m_tag[a] == c_rob;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [4:0] exp_tag(input logic [4:0] a);
        return bypass(a) ? 5'd0 : m_tag[a];
    endfunction

    function automatic logic [31:0] exp_val(input logic [4:0] a);
        return bypass(a) ? c_val : m_val[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_val[i] = '0;
            m_tag[i] = '0;
        end
    endtask

    task automatic idle();
        rdy = 1'b1; clr = 1'b0; l_rdy = 1'b0; c_rdy = 1'b0;
    endtask

    task automatic chk_ports();
        chk("q1_tag", {27'd0, dep1}, {27'd0, exp_tag(ask1)});
        chk("q1_val", val1, exp_val(ask1));
        chk("q2_tag", {27'd0, dep2}, {27'd0, exp_tag(ask2)});
        chk("q2_val", val2, exp_val(ask2));
    endtask

    // Check queries before the edge, apply the architectural rules to the model, cross the edge.
    task automatic tick();
        logic [4:0] old_tag;
        #2;
        chk_ports();
        if (rdy) begin
            old_tag = m_tag[c_reg];
            if (c_rdy && c_reg != 0) m_val[c_reg] = c_val;
            if (clr) begin
                for (int i = 0; i < 32; i++) m_tag[i] = '0;
            end else begin
                if (l_rdy && l_reg != 0) m_tag[l_reg] = l_rob;
                if (c_rdy && c_reg != 0 && !(l_rdy && l_reg == c_reg) && old_tag == c_rob)
                    m_tag[c_reg] = '0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [4:0] rob, input logic [4:0] r);
        l_rdy = 1'b1; l_rob = rob; l_reg = r;
    endtask

    task automatic commit(input logic [4:0] rob, input logic [4:0] r, input logic [31:0] v);
        c_rdy = 1'b1; c_rob = rob; c_reg = r; c_val = v;
    endtask

    // Registered state of one register against fixed expectations.
    task automatic expect_q(input string tag, input logic [4:0] a,
                            input logic [4:0] t, input logic [31:0] v);
        idle();
        ask1 = a;
        #1;
        chk({tag, "_tag"}, {27'd0, dep1}, {27'd0, t});
        chk({tag, "_val"}, val1, v);
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b0; clr = 1'b0; l_rdy = 1'b0; c_rdy = 1'b0;
        l_rob = '0; l_reg = '0; c_rob = '0; c_reg = '0; c_val = '0;
        ask1 = 5'd5; ask2 = 5'd0;
        model_reset();
        #3;
        chk("rst_q1_tag", {27'd0, dep1}, 32'd0);
        chk("rst_q1_val", val1, 32'd0);
        chk("rst_q2_tag", {27'd0, dep2}, 32'd0);
        chk("rst_q2_val", val2, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        idle();

        // Launch then commit with matching tag.
        launch(5'd3, 5'd5); ask1 = 5'd5; ask2 = 5'd5; tick();
        expect_q("t2_launch", 5'd5, 5'd3, 32'd0);
        commit(5'd3, 5'd5, 32'h1234); tick();
        expect_q("t2_commit", 5'd5, 5'd0, 32'h1234);

        // Stale commit leaves the newer producer's tag.
        launch(5'd3, 5'd7); tick();
        launch(5'd9, 5'd7); tick();
        idle(); commit(5'd3, 5'd7, 32'hAA); tick();
        expect_q("t3_stale", 5'd7, 5'd9, 32'hAA);

        // Same-cycle launch and commit to one register.
        launch(5'd4, 5'd4); tick();
        launch(5'd12, 5'd4); commit(5'd4, 5'd4, 32'h55); tick();
        expect_q("t4_both", 5'd4, 5'd12, 32'h55);

        // Clear with a simultaneous launch, then x0 writes.
        launch(5'd1, 5'd1); tick();
        launch(5'd2, 5'd2); tick();
        launch(5'd3, 5'd3); tick();
        idle(); clr = 1'b1; launch(5'd6, 5'd8); tick();
        expect_q("t5_x1", 5'd1, 5'd0, 32'd0);
        expect_q("t5_x8", 5'd8, 5'd0, 32'd0);
        expect_q("t5_x7", 5'd7, 5'd0, 32'hAA);
        launch(5'd10, 5'd0); commit(5'd10, 5'd0, 32'hDEAD); tick();
        expect_q("t5_x0", 5'd0, 5'd0, 32'd0);

        // Stalled cycle holds state.
        launch(5'd20, 5'd5); commit(5'd7, 5'd5, 32'hFFFF); rdy = 1'b0; tick();
        expect_q("t6_stall", 5'd5, 5'd0, 32'h1234);

        // Same-cycle commit visibility on a query.
        launch(5'd2, 5'd6); tick();
        idle(); commit(5'd2, 5'd6, 32'h99); ask1 = 5'd6; ask2 = 5'd6;
        #1;
`ifdef REGFILE_COMMIT_BYPASS_EN
        chk("t6_byp_tag", {27'd0, dep2}, 32'd0);
        chk("t6_byp_val", val2, 32'h99);
`else
        chk("t6_nobyp_tag", {27'd0, dep2}, 32'd2);
        chk("t6_nobyp_val", val2, 32'd0);
`endif
        tick();
        expect_q("t6_after", 5'd6, 5'd0, 32'h99);

        // Asynchronous reset mid-cycle with tags pending.
        launch(5'd11, 5'd9); tick();
        idle(); ask1 = 5'd9; ask2 = 5'd5;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_tag", {27'd0, dep1}, 32'd0);
        chk("arst_val", val2, 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Randomized traffic on a narrow register window to force collisions.
        for (int n = 0; n < 400; n++) begin
            rdy   = ($urandom % 8) != 0;
            clr   = ($urandom % 32) == 0;
            l_rdy = $urandom % 2;
            l_reg = 5'($urandom % 8);
            l_rob = 5'($urandom_range(1, 31));
            c_rdy = $urandom % 2;
            c_reg = 5'($urandom % 8);
            c_rob = ($urandom % 2) ? m_tag[c_reg] : 5'($urandom_range(1, 31));
            c_val = $urandom;
            ask1  = ($urandom % 2) ? c_reg : 5'($urandom % 8);
            ask2  = 5'($urandom);
            tick();
        end

        // Full sweep of registered state.
        idle();
        for (int a = 0; a < 32; a++) begin
            ask1 = 5'(a);
            ask2 = 5'(31 - a);
            @(negedge clk);
            chk_ports();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rename_register_file.md
Name: rename_register_file

Overview:
- Architectural register file with per-register rename tags. It sits directly downstream of the reorder buffer.
- It records which ROB entry will produce each register (launch). It writes committed values and clears the matching tag (commit).
- It answers the ROB's two dependency queries combinationally.
- It drops all rename tags on a misprediction clear.

Parameters:
- XLEN, 32, data width of each register.
- REG_NUM, 32, number of architectural registers (x0..x31).
- ROB_ID_W, 5, ROB tag width; tag 0 means "no pending producer", valid ROB ids are 1..31.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset, asynchronous, active-high
- rdy_in  input  1  ready; all state holds when low
- _clear  input  1  misprediction flush from ROB
- _rf_launch_ready  input  1  new rd rename this cycle
- _rf_launch_rob_id  input  5  ROB id of the producer
- _rf_launch_register_id  input  5  destination register
- _rf_commit_ready  input  1  commit writes a register this cycle
- _rf_commit_rob_id  input  5  ROB id being committed
- _rf_commit_register_id  input  5  destination register
- _rf_commit_value  input  32  committed value
- _ask_rd_1  input  5  query register 1
- _ask_rd_2  input  5  query register 2
- _dep_rd_1  output  5  pending ROB tag of _ask_rd_1 (0 = none)
- _dep_value_1  output  32  register value of _ask_rd_1
- _dep_rd_2  output  5  pending ROB tag of _ask_rd_2
- _dep_value_2  output  32  register value of _ask_rd_2

Behaviour:
- State: value[0..31] (XLEN), tag[0..31] (ROB_ID_W).
- Reset (asynchronous, rst_in high): all values and all tags become 0, regardless of clock or rdy_in.
- Outputs are combinational from state; in reset they read 0.
- x0: value[0] and tag[0] are constant 0. Launch and commit targeting register 0 are ignored.
- rdy_in=0: no state update; queries still answer combinationally.
- Commit (posedge, rdy_in=1, _rf_commit_ready=1, reg r != 0):
  - value[r] <= _rf_commit_value.
  - tag[r] <= 0 only if tag[r] == _rf_commit_rob_id and no launch to r is active this cycle.
  - A stale tag mismatch leaves the tag untouched; a newer producer keeps ownership.
- Launch (posedge, rdy_in=1, _rf_launch_ready=1, _clear=0, reg r != 0): tag[r] <= _rf_launch_rob_id.
- Launch and commit to the same register in the same cycle:
  - The value is written.
  - The tag takes the launch id. Launch has priority over the commit tag clear.
- Clear (posedge, rdy_in=1, _clear=1):
  - All tags <= 0.
  - Any launch that cycle is discarded.
  - A commit value write in the same cycle is still performed.
- Query: _dep_rd_n = tag[_ask_rd_n], _dep_value_n = value[_ask_rd_n], zero latency.
- Both query ports are independent and may address the same register.
- Launches take effect at the next posedge; a same-cycle query sees the old tag.
- Tag wrap: ROB ids recycle 1..31; the equality check on commit is the only ownership test. No ordering comparison is made.

Optional Feature:
- Macro: REGFILE_COMMIT_BYPASS_EN.
- Defined: if _rf_commit_ready=1, _rf_commit_register_id == _ask_rd_n != 0, and tag[_ask_rd_n] == _rf_commit_rob_id, then the query port returns _dep_rd_n = 0 and _dep_value_n = _rf_commit_value in the same cycle.
- Not defined: queries return registered state only. The committed value and cleared tag are visible one cycle after the commit edge.

Test Plan:
1. Reset, then query x5 and x0 -> _dep_rd = 0 and _dep_value = 0 on both ports. Pulse rst_in high mid-run with tags set -> all tags and values 0 immediately, without waiting for a clock edge.
2. Launch (rob 3, x5); next cycle query x5 -> _dep_rd_1 = 3. Commit (rob 3, x5, 0x1234) -> next cycle _dep_rd_1 = 0, _dep_value_1 = 0x1234.
3. Launch (rob 3, x7), then launch (rob 9, x7), then commit (rob 3, x7, 0xAA) -> value[7] = 0xAA, tag[7] stays 9.
4. Same-cycle launch (rob 12, x4) and commit (rob 4, x4, 0x55) with tag[4] = 4 -> tag[4] = 12, value[4] = 0x55.
5. Tags set on x1, x2, x3; assert _clear with a simultaneous launch (rob 6, x8) -> all tags 0, x8 tag 0, values unchanged. Launch and commit to x0 -> x0 stays 0/0.
6. With rdy_in = 0, drive launch and commit -> no change. With REGFILE_COMMIT_BYPASS_EN defined, a commit (rob 2, x6, 0x99) while querying x6 with tag 2 -> same cycle _dep_rd = 0, _dep_value = 0x99. Without the macro -> same cycle shows tag 2 and the old value.
